// File: rtl/inst_fetch_queue.sv
// Circular FIFO of (pc, instruction) pairs between the i-cache output and the i2d register.
// Fetch can run up to DEPTH instructions ahead of decode; flush empties the queue in one cycle.
module inst_fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enq_valid,
    input  logic [ADDR_WIDTH-1:0] enq_pc,
    input  logic [DATA_WIDTH-1:0] enq_data,
    output logic                  enq_ready,
    output logic                  deq_valid,
    output logic [ADDR_WIDTH-1:0] deq_pc,
    output logic [DATA_WIDTH-1:0] deq_data,
    input  logic                  deq_ready,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem_r   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
    logic [PTR_WIDTH-1:0]  rd_ptr_r;
    logic [PTR_WIDTH-1:0]  wr_ptr_r;
    logic [CNT_WIDTH-1:0]  count_r;

    logic full_s;
    logic empty_s;
    logic enq_fire_s;
    logic deq_fire_s;
    logic [CNT_WIDTH-1:0] count_nxt_s;

    // Handshake qualification; flush suppresses both sides.
    always_comb begin
        full_s     = (count_r == FULL_COUNT);
        empty_s    = (count_r == {CNT_WIDTH{1'b0}});
        enq_fire_s = enq_valid && !full_s && !flush;
        deq_fire_s = !empty_s && deq_ready && !flush;
    end

    // Occupancy next-state.
    always_comb begin
        count_nxt_s = count_r;
        case ({enq_fire_s, deq_fire_s})
            2'b10:   count_nxt_s = count_r + CNT_WIDTH'(1);
            2'b01:   count_nxt_s = count_r - CNT_WIDTH'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer and count registers; power-of-two DEPTH makes the increment wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_WIDTH{1'b0}};
            wr_ptr_r <= {PTR_WIDTH{1'b0}};
            count_r  <= {CNT_WIDTH{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_WIDTH{1'b0}};
            wr_ptr_r <= {PTR_WIDTH{1'b0}};
            count_r  <= {CNT_WIDTH{1'b0}};
        end else begin
            if (enq_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_WIDTH'(1);
            end
            if (deq_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1);
            end
            count_r <= count_nxt_s;
        end
    end

    // Storage is never cleared; validity lives entirely in count_r.
    always_ff @(posedge clk) begin
        if (enq_fire_s) begin
            pc_mem_r[wr_ptr_r]   <= enq_pc;
            data_mem_r[wr_ptr_r] <= enq_data;
        end
    end

    // Outputs derive only from registered state, so reset clears them without a clock.
    always_comb begin
        enq_ready = !full_s;
        deq_valid = !empty_s;
        count     = count_r;
        if (!empty_s) begin
            deq_pc   = pc_mem_r[rd_ptr_r];
            deq_data = data_mem_r[rd_ptr_r];
        end else begin
            deq_pc   = {ADDR_WIDTH{1'b0}};
            deq_data = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomised and directed bench for inst_fetch_queue against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enq_valid = 1'b0;
    logic [31:0] enq_pc = 32'h0;
    logic [31:0] enq_data = 32'h0;
    logic        enq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_data;
    logic        deq_ready = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass = 0;

    logic [31:0] mq_pc[$];
    logic [31:0] mq_data[$];

    inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enq_valid (enq_valid),
        .enq_pc    (enq_pc),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_pc    (deq_pc),
        .deq_data  (deq_data),
        .deq_ready (deq_ready),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO queue with capacity DEPTH.
    always @(posedge clk or negedge rst_n) begin : model
        bit do_enq;
        bit do_deq;
        if (!rst_n) begin
            mq_pc.delete();
            mq_data.delete();
        end else if (flush) begin
            mq_pc.delete();
            mq_data.delete();
        end else begin
            do_enq = enq_valid && (mq_pc.size() < DEPTH);
            do_deq = deq_ready && (mq_pc.size() > 0);
            if (do_deq) begin
                void'(mq_pc.pop_front());
                void'(mq_data.pop_front());
            end
            if (do_enq) begin
                mq_pc.push_back(enq_pc);
                mq_data.push_back(enq_data);
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin : compare
        int sz;
        sz = mq_pc.size();
        check("count", 64'(count), 64'(sz));
        check("enq_ready", 64'(enq_ready), 64'(sz < DEPTH));
        check("deq_valid", 64'(deq_valid), 64'(sz != 0));
        check("deq_pc", 64'(deq_pc), (sz != 0) ? 64'(mq_pc[0]) : 64'h0);
        check("deq_data", 64'(deq_data), (sz != 0) ? 64'(mq_data[0]) : 64'h0);
    end

    // One clock cycle: drive after a falling edge, return at the next falling edge.
    task automatic cyc(input logic ev, input logic [31:0] pc, input logic dr, input logic fl);
        enq_valid = ev;
        enq_pc    = pc;
        enq_data  = $urandom;
        deq_ready = dr;
        flush     = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_heads [4];
        int pdeq;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_count", 64'(count), 64'h0);
        check("reset_enq_ready", 64'(enq_ready), 64'h1);
        check("reset_deq_valid", 64'(deq_valid), 64'h0);

        // Fill, then a dropped fifth enqueue.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
        check("fill_count", 64'(count), 64'h4);
        check("fill_enq_ready", 64'(enq_ready), 64'h0);
        cyc(1'b1, 32'h110, 1'b0, 1'b0);
        check("drop_count", 64'(count), 64'h4);
        check("drop_head", 64'(deq_pc), 64'h100);

        // Drain order.
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", 64'(deq_pc), 64'h100 + 64'(4 * i));
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("drained_valid", 64'(deq_valid), 64'h0);
        check("drained_pc", 64'(deq_pc), 64'h0);
        check("drained_count", 64'(count), 64'h0);

        // Streaming across the pointer wrap.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
            check("stream_pc", 64'(deq_pc), 64'h200 + 64'(4 * i));
            check("stream_count", 64'(count), 64'h1);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("stream_end_count", 64'(count), 64'h0);

        // Full with simultaneous dequeue: the enqueue is refused that cycle.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h280 + 32'(4 * i), 1'b0, 1'b0);
        cyc(1'b1, 32'h300, 1'b1, 1'b0);
        check("fulldeq_count", 64'(count), 64'h3);
        check("fulldeq_head", 64'(deq_pc), 64'h284);
        cyc(1'b1, 32'h300, 1'b1, 1'b0);
        check("retry_count", 64'(count), 64'h3);
        exp_heads[0] = 32'h288;
        exp_heads[1] = 32'h28C;
        exp_heads[2] = 32'h300;
        for (int i = 0; i < 3; i++) begin
            check("retry_order", 64'(deq_pc), 64'(exp_heads[i]));
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
        end

        // Flush wins over a same-cycle enqueue and dequeue.
        cyc(1'b1, 32'h500, 1'b0, 1'b0);
        cyc(1'b1, 32'h504, 1'b0, 1'b0);
        check("preflush_count", 64'(count), 64'h2);
        cyc(1'b1, 32'h508, 1'b1, 1'b1);
        check("flush_count", 64'(count), 64'h0);
        check("flush_valid", 64'(deq_valid), 64'h0);
        check("flush_enq_ready", 64'(enq_ready), 64'h1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("flush_no_ghost", 64'(deq_pc), 64'h0);

        // Asynchronous reset between edges.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0);
        check("prereset_count", 64'(count), 64'h3);
        enq_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("areset_valid", 64'(deq_valid), 64'h0);
        check("areset_count", 64'(count), 64'h0);
        check("areset_enq_ready", 64'(enq_ready), 64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'h700, 1'b0, 1'b0);
        cyc(1'b1, 32'h704, 1'b0, 1'b0);
        check("postreset_head", 64'(deq_pc), 64'h700);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("postreset_next", 64'(deq_pc), 64'h704);

        // Random traffic with shifting dequeue pressure.
        pdeq = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) pdeq = $urandom_range(10, 90);
            cyc($urandom_range(0, 3) != 0, $urandom,
                $urandom_range(0, 99) < pdeq, $urandom_range(0, 31) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Circular FIFO of fetched instructions between the i-cache output and the i2d pipeline register. Fetch can run up to DEPTH instructions ahead of decode, so a decode stall no longer has to stall fetch on the same cycle. Each entry holds a (pc, instruction) pair. The dequeue side drives the i_pc / i_inst inputs of the i2d register. A flush from hazard control empties the queue in one cycle.

## Interface
- DEPTH, default 4: number of entries; power of two, at least 2.
- ADDR_WIDTH, default 32: PC width.
- DATA_WIDTH, default 32: instruction width.
- CNT_WIDTH, default $clog2(DEPTH+1): width of `count`.

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- enq_valid  in  1: fetch presents a valid instruction (i-cache output valid).
- enq_pc  in  ADDR_WIDTH: PC of the presented instruction.
- enq_data  in  DATA_WIDTH: instruction word.
- enq_ready  out  1: queue can accept; equals !full. Does not depend on deq_ready.
- deq_valid  out  1: head entry is valid; equals (count != 0).
- deq_pc  out  ADDR_WIDTH: head PC; '0 when deq_valid=0.
- deq_data  out  DATA_WIDTH: head instruction; '0 when deq_valid=0.
- deq_ready  in  1: decode consumes the head this cycle; driven as !i2d stall.
- flush  in  1: discard all contents (branch mispredict recovery).
- count  out  CNT_WIDTH: current occupancy, 0..DEPTH.

## Operation
- State:
  - storage arrays pc_mem[DEPTH] and data_mem[DEPTH];
  - rd_ptr and wr_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH;
  - count register.
- Enqueue fires when enq_valid && enq_ready && !flush:
  - write enq_pc and enq_data at wr_ptr;
  - wr_ptr advances by 1.
- Dequeue fires when deq_valid && deq_ready && !flush:
  - rd_ptr advances by 1.
- Count update:
  - +1 on enqueue only;
  - -1 on dequeue only;
  - unchanged when both or neither fire.
- Simultaneous enqueue and dequeue at any non-full, non-empty occupancy: both fire, count unchanged.
- Full (count=DEPTH):
  - enq_ready=0 and any enqueue is dropped, even if deq_ready=1 that cycle;
  - fetch must hold its request and retry.
- Empty (count=0):
  - deq_valid=0, no dequeue, and deq_ready is ignored;
  - there is no same-cycle bypass from enq to deq.
- Flush has priority over everything:
  - next cycle rd_ptr=0, wr_ptr=0, count=0;
  - enqueue and dequeue in the flush cycle are both discarded.
- Storage contents are never cleared; validity is defined only by count.
- Reset (asynchronous, any time, including mid-operation): rd_ptr=0, wr_ptr=0, count=0. Outputs go to enq_ready=1, deq_valid=0, deq_pc='0, deq_data='0, count=0 immediately on assertion, without waiting for a clock edge.

## Timing
- Enqueue-to-dequeue latency: an instruction enqueued at edge N is visible at deq_* after edge N, so earliest consumption is at edge N+1.
- Throughput: one enqueue and one dequeue per cycle, sustained at any occupancy from 1 to DEPTH-1.
- deq_pc, deq_data and deq_valid depend only on registered state (the head entry and count). There is no combinational path from enq_* or deq_ready.
- enq_ready depends only on count. There is no combinational path from deq_ready or flush.
- Wrap-around: a pointer at DEPTH-1 advances to 0. A full-to-empty-to-full sequence that crosses the wrap point must preserve FIFO order.
- After a flush at edge N: deq_valid=0 after N, and enq_ready=1 after N.

## Test plan
- Reset then fill: after rst_n deassert, enqueue PCs 0x100, 0x104, 0x108, 0x10C with deq_ready=0 → count=4, enq_ready=0. A fifth enqueue of PC 0x110 is dropped and count stays 4.
- Drain order: from the full state above, hold deq_ready=1 for 4 cycles → deq_pc shows 0x100, 0x104, 0x108, 0x10C on consecutive cycles. Then deq_valid=0, deq_pc=0, count=0.
- Streaming across wrap: enqueue 10 sequential PCs from 0x200 while deq_ready=1 every cycle → each PC appears exactly one cycle after its enqueue, count stays ≤1, and order is preserved across the pointer wrap.
- Full with simultaneous deq: at count=4, assert enq_valid (PC 0x300) and deq_ready together → head is dequeued, 0x300 is not accepted, count=3. Next cycle 0x300 is accepted and count stays 3 (simultaneous enq+deq).
- Flush priority: at count=2, assert flush, enq_valid and deq_ready in the same cycle → next cycle count=0 and deq_valid=0. The enqueued PC never appears at deq_pc.
- Asynchronous reset mid-stream: assert rst_n=0 between clock edges at count=3 → deq_valid=0, count=0 and enq_ready=1 before the next rising edge. After release, the first enqueued PC is the first dequeued.
